// File: rtl/dmem_sequencer_pkg.sv
// dmem_sequencer_pkg
//   Shared types and constants for the data-memory sequencer:
//   FSM state encoding, default access timeout, timeout counter width,
//   and a byte replication helper used by the lane logic.
package dmem_sequencer_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } dmem_state_e;

  function automatic logic [63:0] replicate_byte(input logic [7:0] b);
    return {8{b}};
  endfunction

endpackage

// File: rtl/dmem_sequencer_byte_lane.sv
// byte_lane
//   Combinational lane steering for byte and 64-bit accesses.
//   Ports:
//     i_byte   - 1: byte access, 0: 64-bit access
//     i_lane   - byte lane (address bits [2:0])
//     i_wdata  - store data from the sequencer's latch
//     i_rdata  - raw read data from memory
//     o_be     - byte-lane enable
//     o_wdata  - store data as presented to memory
//     o_rdata  - load result (zero-extended byte or full word)
module byte_lane
  import dmem_sequencer_pkg::*;
(
  input  logic        i_byte,
  input  logic [2:0]  i_lane,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  always_comb begin
    o_be    = 8'hFF;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_byte) begin
      o_be    = 8'h01 << i_lane;
      // Byte stores put the byte on every lane; mem_be picks the live one.
      o_wdata = replicate_byte(i_wdata[7:0]);
      o_rdata = {56'b0, i_rdata[{i_lane, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/dmem_sequencer.sv
// dmem_sequencer
//   Sequences one load/store from the pipeline's main control onto a
//   request/acknowledge memory port, stalling the pipeline until done.
//   Ports:
//     clk, reset            - clock, asynchronous active-low reset
//     MemRead, MemWrite     - load / store command (store has priority)
//     xferByte              - 1: byte transfer, 0: 64-bit transfer
//     addr, wdata           - byte address and store data
//     mem_req, mem_we       - memory request and write strobe
//     mem_addr, mem_wdata   - latched address, lane-steered store data
//     mem_be                - byte-lane enable
//     mem_ack, mem_rdata    - memory completion strobe and read data
//     rdata                 - load result to the MemToReg mux
//     stall                 - hold PC / suppress RegWrite
//     mem_err               - access timed out (sticky until reset)
//
//   state | meaning
//   IDLE  | waiting for a command; stall follows the command combinationally
//   REQ   | request outstanding, counting unacknowledged cycles
//   DONE  | one-cycle completion, rdata valid, stall released
//   ERR   | access timed out; stall and mem_err held until reset
module dmem_sequencer
  import dmem_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        xferByte,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  dmem_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [63:0]      r_addr, r_wdata, r_rdata;
  logic             r_we, r_byte;

  logic             w_cmd, w_accept, w_load_done;
  logic [7:0]       w_be;
  logic [63:0]      w_wdata_lane, w_rdata_lane;

  // A set MemWrite masks whatever MemRead carries; reset masks both so
  // stall stays low while reset is held.
  assign w_cmd = reset & (MemWrite ? 1'b1 : MemRead);

  byte_lane u_byte_lane (
    .i_byte  (r_byte),
    .i_lane  (r_addr[2:0]),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_lane),
    .o_rdata (w_rdata_lane)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_load_done = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 8'h00;
    mem_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd) begin
          stall       = 1'b1;
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = r_we;
        mem_be  = w_be;
        if (mem_ack) begin
          w_load_done = ~r_we;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == TIMEOUT_CNT) w_state_nxt = ERR;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      ERR: begin
        stall   = 1'b1;
        mem_err = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_we    <= MemWrite;
        r_byte  <= xferByte;
      end
      if (w_load_done) r_rdata <= w_rdata_lane;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = w_wdata_lane;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_sequencer.sv
module tb_dmem_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, xferByte = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] rdata;
  logic        stall, mem_err;

  int total = 0;
  int bad   = 0;

  dmem_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .xferByte  (xferByte),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  localparam int P_IDLE = 0, P_REQ = 1, P_DONE = 2, P_ERR = 3;
  int          m_phase = P_IDLE;
  int          m_reqs  = 0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_we = 1'b0, m_byte = 1'b0;

  function automatic int lane_of(input logic [63:0] a);
    return int'(a % 64'd8);
  endfunction

  function automatic logic [7:0] exp_be();
    if (!m_byte) return 8'hFF;
    return 8'(1 << lane_of(m_addr));
  endfunction

  function automatic logic [63:0] exp_wdata();
    logic [63:0] r;
    if (!m_byte) return m_wdata;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_wdata[7:0];
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_IDLE; m_reqs = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0; m_byte = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (MemWrite || MemRead) begin
          m_addr = addr; m_wdata = wdata; m_we = MemWrite; m_byte = xferByte;
          m_reqs = 0; m_phase = P_REQ;
        end
        P_REQ: if (mem_ack) begin
          if (!m_we)
            m_rdata = m_byte ? ((mem_rdata >> (8 * lane_of(m_addr))) & 64'hFF) : mem_rdata;
          m_phase = P_DONE;
        end else begin
          m_reqs++;
          if (m_reqs == TO) m_phase = P_ERR;
        end
        P_DONE: m_phase = P_IDLE;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic in_req, e_stall;
    in_req  = (m_phase == P_REQ);
    e_stall = in_req || (m_phase == P_ERR) ||
              (m_phase == P_IDLE && reset && (MemWrite || MemRead));
    chk("mdl_mem_req",   {63'b0, mem_req}, {63'b0, in_req});
    chk("mdl_mem_we",    {63'b0, mem_we},  {63'b0, in_req && m_we});
    chk("mdl_mem_be",    {56'b0, mem_be},  {56'b0, in_req ? exp_be() : 8'h00});
    chk("mdl_mem_addr",  mem_addr,  m_addr);
    chk("mdl_mem_wdata", mem_wdata, exp_wdata());
    chk("mdl_rdata",     rdata,     m_rdata);
    chk("mdl_stall",     {63'b0, stall},   {63'b0, e_stall});
    chk("mdl_mem_err",   {63'b0, mem_err}, {63'b0, m_phase == P_ERR});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input logic rd, input logic wr, input logic byt,
                         input logic [63:0] a, input logic [63:0] wd);
    MemRead = rd; MemWrite = wr; xferByte = byt; addr = a; wdata = wd;
  endtask

  task automatic idle_cmd();
    MemRead = 1'b0; MemWrite = 1'b0; xferByte = 1'b0;
  endtask

  // Presents a command at posedge+1, acks on REQ cycle n_req, holds the
  // command through DONE, and returns at posedge+1 of the following IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic byt,
                            input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] rv, input int n_req,
                            output int stall_hi, output logic done_stall,
                            output logic [63:0] done_rdata, output logic [7:0] req_be,
                            output logic [63:0] req_wdata, output logic req_we,
                            output logic [63:0] req_addr);
    set_cmd(rd, wr, byt, a, wd);
    mem_ack = 1'b0; mem_rdata = rv; stall_hi = 0;
    @(negedge clk); if (stall) stall_hi++;
    for (int i = 1; i <= n_req; i++) begin
      tick();
      mem_ack = (i == n_req);
      @(negedge clk); if (stall) stall_hi++;
      req_be = mem_be; req_wdata = mem_wdata; req_we = mem_we; req_addr = mem_addr;
    end
    tick();
    mem_ack = 1'b0;
    @(negedge clk); if (stall) stall_hi++;
    done_stall = stall; done_rdata = rdata;
    tick();
    idle_cmd();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sh, reqs;
    logic        ds, rwe, err_seen;
    logic [63:0] dr, rwd, rad;
    logic [7:0]  rbe;

    #22 reset = 1'b1;
    tick();

    // LDUR, ack on second REQ cycle
    run_access(1, 0, 0, 64'h10, 64'h0, 64'h1122334455667788, 2, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("ldur_stall_cycles", 64'(sh), 64'd3);
    chk("ldur_done_stall", {63'b0, ds}, 64'd0);
    chk("ldur_rdata", dr, 64'h1122334455667788);
    chk("ldur_be", {56'b0, rbe}, 64'hFF);
    chk("ldur_addr", rad, 64'h10);

    // LDURB lane 3
    run_access(1, 0, 1, 64'h13, 64'h0, 64'h1122334455667788, 1, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("ldurb_be", {56'b0, rbe}, 64'h08);
    chk("ldurb_rdata", dr, 64'h0000000000000055);
    chk("ldurb_addr_unaligned", rad, 64'h13);

    // STURB lane 5, immediate ack
    run_access(0, 1, 1, 64'h5, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 1, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("sturb_we", {63'b0, rwe}, 64'd1);
    chk("sturb_be", {56'b0, rbe}, 64'h20);
    chk("sturb_wdata", rwd, 64'hABABABABABABABAB);
    chk("sturb_stall_cycles", 64'(sh), 64'd2);
    chk("sturb_done_stall", {63'b0, ds}, 64'd0);
    chk("sturb_rdata_kept", dr, 64'h0000000000000055);

    // LDURB top lane
    run_access(1, 0, 1, 64'h2F, 64'h0, 64'h1122334455667788, 3, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("ldurb7_be", {56'b0, rbe}, 64'h80);
    chk("ldurb7_rdata", dr, 64'h11);
    chk("ldurb7_stall_cycles", 64'(sh), 64'd4);

    // back-to-back LDUR then STUR
    run_access(1, 0, 0, 64'h20, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 1, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("b2b_ld_stall_cycles", 64'(sh), 64'd2);
    chk("b2b_ld_rdata", dr, 64'hA5A5_5A5A_0F0F_F0F0);
    run_access(0, 1, 0, 64'h28, 64'h0102030405060708, 64'h0, 1, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("b2b_st_stall_cycles", 64'(sh), 64'd2);
    chk("b2b_st_wdata", rwd, 64'h0102030405060708);
    chk("b2b_st_be", {56'b0, rbe}, 64'hFF);
    chk("b2b_st_we", {63'b0, rwe}, 64'd1);

    // reset during REQ, then a stray ack
    set_cmd(1, 0, 0, 64'h40, 64'h0);
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    @(negedge clk);
    chk("rst_pre_req", {63'b0, mem_req}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_be", {56'b0, mem_be}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    idle_cmd();
    @(negedge clk); #1 reset = 1'b1;
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_req", {63'b0, mem_req}, 64'd0);
    chk("stray_ack_stall", {63'b0, stall}, 64'd0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdata", rdata, 64'd0);
    chk("stray_ack_stall2", {63'b0, stall}, 64'd0);
    tick();

    // STUR with MemRead unknown, never acked -> timeout
    set_cmd(1'bx, 1, 0, 64'h30, 64'h55AA_55AA_55AA_55AA);
    reqs = 0; err_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_err) begin err_seen = 1'b1; break; end
      if (mem_req) reqs++;
    end
    chk("to_err_seen", {63'b0, err_seen}, 64'd1);
    chk("to_req_cycles", 64'(reqs), 64'd15);
    idle_cmd();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("to_err_sticky", {63'b0, mem_err}, 64'd1);
      chk("to_stall_sticky", {63'b0, stall}, 64'd1);
      chk("to_req_low", {63'b0, mem_req}, 64'd0);
    end
    #1 reset = 1'b0;
    #1;
    chk("to_rst_err", {63'b0, mem_err}, 64'd0);
    chk("to_rst_stall", {63'b0, stall}, 64'd0);
    @(negedge clk); #1 reset = 1'b1;
    tick();

    // recovery after error: word load
    run_access(1, 0, 0, 64'h38, 64'h0, 64'h0123456789ABCDEF, 1, sh, ds, dr, rbe, rwd, rwe, rad);
    chk("post_err_rdata", dr, 64'h0123456789ABCDEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
